shift_sequencer: RTL and testbench

- Parametrised successor of the 8-bit left/right tristate shift register.
- WIDTH-bit universal register with shared tristate parallel I/O, plus rotate and arithmetic modes.
- Adds a burst sequencer: one start pulse performs a counted multi-step shift, with busy/done handshake.
- Used as a drop-in generalised shifter/serialiser in TTL-level board models.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 130 +++++++++++++
 tb/tb_shift_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer control/status bundle: mode/burst controls, serial inputs,
// output enables and the registered status outputs. The tristate parallel bus
// qio stays a plain inout on the module so that the net resolution lives at
// the board level.
interface shift_sequencer_if #(
  parameter int unsigned CNTW = 4
);
  logic [2:0]      mode;
  logic            start;
  logic [CNTW-1:0] cnt;
  logic            sl;
  logic            sr;
  logic            g1;
  logic            g2;
  logic            q_lo;
  logic            q_hi;
  logic            busy;
  logic            done;

  modport master (
    output mode, start, cnt, sl, sr, g1, g2,
    input  q_lo, q_hi, busy, done
  );

  modport slave (
    input  mode, start, cnt, sl, sr, g1, g2,
    output q_lo, q_hi, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: WIDTH-bit universal shift register with shared tristate
// parallel I/O, rotate/arithmetic modes and a counted burst sequencer.
// "Right" moves bits towards the MSB (sr enters bit 0); "left" moves them
// towards the LSB (sl enters bit WIDTH-1).
// Optional feature: define SHIFT_SEQUENCER_CARRY_EN to add the carry-out port co.
// tPD/tPZ are board-model timing annotations; the RTL is zero-delay.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4,
  parameter int          tPD   = 25,
  parameter int          tPZ   = 21
) (
  input  logic                 clk,
  input  logic                 clr,
  shift_sequencer_if.slave     bus,
  inout  wire  [WIDTH-1:0]     qio
`ifdef SHIFT_SEQUENCER_CARRY_EN
  ,
  output logic                 co
`endif
);

  if (WIDTH < 2 || tPD < 0 || tPZ < 0) begin : g_param_check
    $error("shift_sequencer: WIDTH must be >= 2 and delays non-negative");
  end

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [2:0] M_LOAD = 3'b011;

  logic [0:0]       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] nxt;
  logic [2:0]       bmode;
  logic [2:0]       emode;
  logic [CNTW-1:0]  bcnt;
  logic             done_q;
  logic             drive;

  // Next register value for one step of the effective mode (live mode when
  // idle, latched burst mode otherwise).
  always_comb begin
    emode = (state == BURST) ? bmode : bus.mode;
    nxt   = r;
    case (emode)
      3'b001:  nxt = {r[WIDTH-2:0], bus.sr};
      3'b010:  nxt = {bus.sl, r[WIDTH-1:1]};
      3'b011:  nxt = qio;
      3'b100:  nxt = {r[WIDTH-2:0], r[WIDTH-1]};
      3'b101:  nxt = {r[0], r[WIDTH-1:1]};
      3'b110:  nxt = {r[WIDTH-1], r[WIDTH-1:1]};
      default: nxt = r;
    endcase
  end

  // Register, burst sequencer and done pulse. A burst edge with bcnt==0
  // performs no step and finishes, giving cnt steps over cnt+1 edges; a load
  // burst performs its single load and finishes on the same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      r      <= '0;
      bmode  <= '0;
      bcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          state <= BURST;
          bmode <= bus.mode;
          bcnt  <= bus.cnt;
        end else begin
          r <= nxt;
        end
      end else begin
        if (bmode == M_LOAD) begin
          r      <= nxt;
          state  <= IDLE;
          done_q <= 1'b1;
        end else if (bcnt == '0) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end else begin
          r    <= nxt;
          bcnt <= bcnt - CNTW'(1);
        end
      end
    end
  end

`ifdef SHIFT_SEQUENCER_CARRY_EN
  logic shifting;
  logic sout;
  logic step_en;

  // Bit leaving the register for the effective mode; load/hold do not shift.
  always_comb begin
    shifting = 1'b1;
    sout     = r[0];
    case (emode)
      3'b001, 3'b100:         sout = r[WIDTH-1];
      3'b010, 3'b101, 3'b110: sout = r[0];
      default:                shifting = 1'b0;
    endcase
  end

  assign step_en = (state == IDLE) ? !bus.start : (bcnt != '0);

  // Carry register updated only on edges that actually shift or rotate.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      co <= 1'b0;
    end else if (step_en && shifting) begin
      co <= sout;
    end
  end
`endif

  // The parallel bus floats while disabled or while an idle load wants to read it.
  assign drive = !(bus.g1 || bus.g2) && !(state == IDLE && bus.mode == M_LOAD);
  assign qio   = drive ? r : 'z;

  assign bus.q_lo = r[0];
  assign bus.q_hi = r[WIDTH-1];
  assign bus.busy = (state == BURST);
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (WIDTH=8, CNTW=4): directed
// scenarios followed by randomized idle operations and bursts, all compared
// against an arithmetic reference model of the register.
module tb_shift_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         tb_drv;
  logic [W-1:0] tb_val;
  tri1  [W-1:0] qio;
`ifdef SHIFT_SEQUENCER_CARRY_EN
  logic         co;
  logic         mco;
`endif

  logic [W-1:0] mdl;
  int           n_checks = 0;
  int           n_pass   = 0;

  shift_sequencer_if #(.CNTW(C)) bus ();

  shift_sequencer #(
    .WIDTH (W),
    .CNTW  (C),
    .tPD   (25),
    .tPZ   (21)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave),
    .qio (qio)
`ifdef SHIFT_SEQUENCER_CARRY_EN
    ,
    .co  (co)
`endif
  );

  assign qio = tb_drv ? tb_val : 'z;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference step: register treated as an integer 0..255.
  function automatic logic [W-1:0] ref_step(input logic [2:0] m, input logic [W-1:0] rv,
                                            input logic vsl, input logic vsr,
                                            input logic [W-1:0] ld);
    int v;
    v = int'(rv);
    case (m)
      3'd1:    v = (v * 2 + int'(vsr)) % 256;
      3'd2:    v = v / 2 + int'(vsl) * 128;
      3'd3:    v = int'(ld);
      3'd4:    v = (v * 2) % 256 + v / 128;
      3'd5:    v = v / 2 + (v % 2) * 128;
      3'd6:    v = v / 2 + (v / 128) * 128;
      default: v = v;
    endcase
    return W'(v);
  endfunction

  task automatic upd_carry(input logic [2:0] m, input logic [W-1:0] rv);
`ifdef SHIFT_SEQUENCER_CARRY_EN
    if (m == 3'd1 || m == 3'd4) mco = (rv >= 8'd128);
    else if (m == 3'd2 || m == 3'd5 || m == 3'd6) mco = rv[0];
`else
    if (m == 3'd7 && rv == '0) begin end
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic eb, input logic ed);
    check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, eb});
    check({tag, ".done"}, {31'd0, bus.done}, {31'd0, ed});
    check({tag, ".q_lo"}, {31'd0, bus.q_lo}, {31'd0, mdl[0]});
    check({tag, ".q_hi"}, {31'd0, bus.q_hi}, {31'd0, mdl[W-1]});
    if (!tb_drv) begin
      if (bus.g1 || bus.g2 || (!eb && bus.mode == 3'b011))
        check({tag, ".qio_z"}, {24'd0, qio}, 32'h0000_00FF);
      else
        check({tag, ".qio"}, {24'd0, qio}, {24'd0, mdl});
    end
`ifdef SHIFT_SEQUENCER_CARRY_EN
    check({tag, ".co"}, {31'd0, co}, {31'd0, mco});
`endif
  endtask

  task automatic idle_op(input string tag, input logic [2:0] m, input logic vsl, input logic vsr,
                         input logic vg1, input logic vg2, input logic [W-1:0] ld);
    logic [W-1:0] e;
    bus.mode  = m;
    bus.start = 1'b0;
    bus.sl    = vsl;
    bus.sr    = vsr;
    bus.g1    = vg1;
    bus.g2    = vg2;
    tb_drv    = (m == 3'd3);
    tb_val    = ld;
    e = ref_step(m, mdl, vsl, vsr, ld);
    upd_carry(m, mdl);
    tick;
    mdl = e;
    check_state(tag, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle_op("load", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, v);
    tb_drv   = 1'b0;
    bus.mode = 3'd0;
  endtask

  // A burst of mode m with count c: c stepping edges after the start edge,
  // then one finishing edge with done. Controls are scrambled mid-burst.
  task automatic run_burst(input string tag, input logic [2:0] m, input logic [C-1:0] c,
                           input logic vsl, input logic vsr);
    bus.mode  = m;
    bus.cnt   = c;
    bus.start = 1'b1;
    bus.sl    = vsl;
    bus.sr    = vsr;
    bus.g1    = 1'b0;
    bus.g2    = 1'b0;
    tb_drv    = 1'b0;
    tick;
    check_state({tag, ".start"}, 1'b1, 1'b0);
    for (int k = 1; k <= int'(c); k++) begin
      bus.mode  = 3'($urandom);
      bus.start = 1'($urandom);
      bus.cnt   = C'($urandom);
      upd_carry(m, mdl);
      mdl = ref_step(m, mdl, vsl, vsr, '0);
      tick;
      check_state({tag, ".step"}, 1'b1, 1'b0);
    end
    bus.mode  = 3'd0;
    bus.start = 1'b0;
    tick;
    check_state({tag, ".end"}, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] keep;
    logic [2:0]   m;
    clr       = 1'b1;
    tb_drv    = 1'b0;
    tb_val    = '0;
    bus.mode  = 3'd0;
    bus.start = 1'b0;
    bus.cnt   = '0;
    bus.sl    = 1'b0;
    bus.sr    = 1'b0;
    bus.g1    = 1'b0;
    bus.g2    = 1'b0;
    mdl       = '0;
`ifdef SHIFT_SEQUENCER_CARRY_EN
    mco       = 1'b0;
`endif
    #3;
    check_state("reset", 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    // Idle load, readback and output disables.
    do_load(8'hA5);
    idle_op("hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("load_a5", {24'd0, qio}, 32'h0000_00A5);
    idle_op("g2_off", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("g2_float", {24'd0, qio}, 32'h0000_00FF);
    idle_op("g1_off", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Counted shift-right burst.
    do_load(8'h81);
    run_burst("shr3", 3'd1, 4'd3, 1'b1, 1'b0);
    check("shr3_val", {24'd0, qio}, 32'h0000_0008);

    // Rotate right by one.
    do_load(8'h81);
    run_burst("ror1", 3'd4, 4'd1, 1'b0, 1'b0);
    check("ror1_val", {24'd0, qio}, 32'h0000_0003);
`ifdef SHIFT_SEQUENCER_CARRY_EN
    check("ror1_co", {31'd0, co}, 32'd1);
`endif

    // Arithmetic left twice.
    do_load(8'h90);
    run_burst("asl2", 3'd6, 4'd2, 1'b0, 1'b0);
    check("asl2_val", {24'd0, qio}, 32'h0000_00E4);

    // Zero-length burst, then a start issued in its done cycle.
    keep = mdl;
    run_burst("cnt0", 3'd5, 4'd0, 1'b0, 1'b0);
    check("cnt0_val", {24'd0, qio}, {24'd0, keep});
    run_burst("b2b", 3'd2, 4'd2, 1'b1, 1'b0);

    // Asynchronous clear in the middle of a burst.
    do_load(8'h5A);
    bus.mode  = 3'd1;
    bus.cnt   = 4'd9;
    bus.start = 1'b1;
    bus.sr    = 1'b1;
    tick;
    check_state("clr.start", 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      upd_carry(3'd1, mdl);
      mdl = ref_step(3'd1, mdl, 1'b0, 1'b1, '0);
      tick;
      check_state("clr.step", 1'b1, 1'b0);
    end
    bus.mode = 3'd0;
    #2 clr = 1'b1;
    #1;
    mdl = '0;
`ifdef SHIFT_SEQUENCER_CARRY_EN
    mco = 1'b0;
`endif
    check_state("clr.async", 1'b0, 1'b0);
    #1 clr = 1'b0;
    for (int k = 0; k < 3; k++) idle_op("clr.after", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Randomized mix of idle operations and bursts.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        idle_op("rnd_idle", 3'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), W'($urandom));
      end else begin
        do m = 3'($urandom); while (m == 3'd3);
        run_burst("rnd_burst", m, C'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    tb_drv = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
